// File: rtl/glitch_pkg.sv
`default_nettype none
// ==== glitch_pkg -- shared states, default sweep constants and engine request type. Rev 1.0 ====
package glitch_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_ARM       = 3'd1,
      ST_WAIT_TRIG = 3'd2,
      ST_FIRE      = 3'd3,
      ST_OBSERVE   = 3'd4,
      ST_NEXT      = 3'd5,
      ST_FINISH    = 3'd6
   } sweep_state_t;

   localparam int unsigned DEF_DW          = 32;
   localparam int unsigned DEF_DELAY_START = 0;
   localparam int unsigned DEF_DELAY_END   = 1000;
   localparam int unsigned DEF_DELAY_STEP  = 10;
   localparam int unsigned DEF_WIDTH_START = 1;
   localparam int unsigned DEF_WIDTH_END   = 8;
   localparam int unsigned DEF_WIDTH_STEP  = 1;
   localparam int unsigned DEF_REPEATS     = 4;
   localparam int unsigned DEF_OBS_CYCLES  = 1024;

   typedef struct packed {
      logic [DEF_DW-1:0] delay;
      logic [DEF_DW-1:0] width;
   } eng_req_t;

endpackage
`default_nettype wire

// File: rtl/glitch_param_stepper.sv
`default_nettype none
// ==== glitch_param_stepper -- one sweep axis: load, step by STEP, wrap to START past END. Rev 1.0 ====
module glitch_param_stepper #(
   parameter int unsigned   DW    = 32,
   parameter logic [DW-1:0] START = '0,
   parameter logic [DW-1:0] END   = '0,
   parameter logic [DW-1:0] STEP  = DW'(1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load,
   input  logic          step_en,
   output logic [DW-1:0] value,
   output logic          wrap
);

   logic [DW:0] sum;

   // One extra bit so a carry out of DW bits also counts as past END.
   assign sum  = {1'b0, value} + {1'b0, STEP};
   assign wrap = (sum > {1'b0, END});

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         value <= '0;
      end else if (load) begin
         value <= START;
      end else if (step_en) begin
         value <= wrap ? START : sum[DW-1:0];
      end
   end

endmodule
`default_nettype wire

// File: rtl/glitch_sweep_ctrl.sv
`default_nettype none
// ==== glitch_sweep_ctrl -- (delay, width, repeat) glitch campaign sequencer. Rev 1.0 ====
module glitch_sweep_ctrl
   import glitch_pkg::*;
#(
   parameter int unsigned DW          = DEF_DW,
   parameter int unsigned DELAY_START = DEF_DELAY_START,
   parameter int unsigned DELAY_END   = DEF_DELAY_END,
   parameter int unsigned DELAY_STEP  = DEF_DELAY_STEP,
   parameter int unsigned WIDTH_START = DEF_WIDTH_START,
   parameter int unsigned WIDTH_END   = DEF_WIDTH_END,
   parameter int unsigned WIDTH_STEP  = DEF_WIDTH_STEP,
   parameter int unsigned REPEATS     = DEF_REPEATS,
   parameter int unsigned OBS_CYCLES  = DEF_OBS_CYCLES
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          abort,
   input  logic          trigger,
   input  logic          fault_in,
   output logic          eng_start,
   output logic [DW-1:0] eng_delay,
   output logic [DW-1:0] eng_width,
   input  logic          eng_done,
   output logic          busy,
   output logic          done,
   output logic          hit,
   output logic [DW-1:0] cur_delay,
   output logic [DW-1:0] cur_width
);

   localparam logic [DW-1:0] C_DELAY_START = DW'(DELAY_START);
   localparam logic [DW-1:0] C_DELAY_END   = DW'(DELAY_END);
   localparam logic [DW-1:0] C_DELAY_STEP  = DW'(DELAY_STEP);
   localparam logic [DW-1:0] C_WIDTH_START = DW'(WIDTH_START);
   localparam logic [DW-1:0] C_WIDTH_END   = DW'(WIDTH_END);
   localparam logic [DW-1:0] C_WIDTH_STEP  = DW'(WIDTH_STEP);
   localparam logic [31:0]   C_REP_LAST    = 32'(REPEATS - 1);
   localparam logic [31:0]   C_OBS_LAST    = 32'(OBS_CYCLES - 1);

   sweep_state_t  state;
   sweep_state_t  state_nx;
   logic          trig_q;
   logic [31:0]   rep;
   logic [31:0]   obs_cnt;
   logic [DW-1:0] delay_val;
   logic [DW-1:0] width_val;
   logic          delay_wrap;
   logic          width_wrap;
   logic          trig_rise;
   logic          rep_last;
   logic          obs_last;
   logic          sweep_end;
   logic          load;
   logic          advance;
   logic          width_step;
   logic          delay_step;
   logic          fault_seen;

   assign trig_rise  = trigger & ~trig_q;
   assign rep_last   = (rep == C_REP_LAST);
   assign obs_last   = (obs_cnt == C_OBS_LAST);
   assign sweep_end  = rep_last & width_wrap & delay_wrap;
   assign load       = (state == ST_IDLE) & start & ~abort;
   // The final point is not stepped, so cur_* keep showing the last point visited.
   assign advance    = (state == ST_NEXT) & ~abort & ~sweep_end;
   assign width_step = advance & rep_last;
   assign delay_step = width_step & width_wrap;
   assign fault_seen = ((state == ST_FIRE) | (state == ST_OBSERVE)) & fault_in & ~abort;

   assign eng_delay  = delay_val;
   assign eng_width  = width_val;
   assign cur_delay  = delay_val;
   assign cur_width  = width_val;

   glitch_param_stepper #(
      .DW    (DW),
      .START (C_WIDTH_START),
      .END   (C_WIDTH_END),
      .STEP  (C_WIDTH_STEP)
   ) u_width (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (load),
      .step_en (width_step),
      .value   (width_val),
      .wrap    (width_wrap)
   );

   glitch_param_stepper #(
      .DW    (DW),
      .START (C_DELAY_START),
      .END   (C_DELAY_END),
      .STEP  (C_DELAY_STEP)
   ) u_delay (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (load),
      .step_en (delay_step),
      .value   (delay_val),
      .wrap    (delay_wrap)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE:      if (start) state_nx = ST_ARM;
         ST_ARM:       if (!trigger) state_nx = ST_WAIT_TRIG;
         ST_WAIT_TRIG: if (trig_rise) state_nx = ST_FIRE;
         ST_FIRE: begin
            if (fault_in)      state_nx = ST_FINISH;
            else if (eng_done) state_nx = ST_OBSERVE;
         end
         ST_OBSERVE: begin
            if (fault_in)      state_nx = ST_FINISH;
            else if (obs_last) state_nx = ST_NEXT;
         end
         ST_NEXT:      state_nx = sweep_end ? ST_FINISH : ST_ARM;
         ST_FINISH:    state_nx = ST_IDLE;
         default:      state_nx = ST_IDLE;
      endcase
      if (abort) state_nx = ST_IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         trig_q    <= 1'b0;
         rep       <= '0;
         obs_cnt   <= '0;
         eng_start <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         hit       <= 1'b0;
      end else begin
         trig_q    <= trigger;
         eng_start <= (state == ST_WAIT_TRIG) && (state_nx == ST_FIRE);
         busy      <= (state_nx != ST_IDLE);
         obs_cnt   <= (state == ST_OBSERVE) ? obs_cnt + 32'd1 : '0;
         if (load) begin
            rep <= '0;
         end else if (advance) begin
            rep <= rep_last ? '0 : rep + 32'd1;
         end
         if (abort || load) begin
            done <= 1'b0;
         end else if (state == ST_FINISH) begin
            done <= 1'b1;
         end
         if (load) begin
            hit <= 1'b0;
         end else if (fault_seen) begin
            hit <= 1'b1;
         end
      end
   end

endmodule
`default_nettype wire
